// File: rtl/seg_decoder.sv
// Registered 4-bit to seven-segment decoder, {dp,g,f,e,d,c,b,a} ordering.
// One register stage keeps the segment drive glitch-free; polarity and hex digits are parameters.
module seg_decoder #(
  parameter logic ACTIVE_LOW = 1'b0,
  parameter logic HEX_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic [7:0] out
);

  localparam logic [7:0] BLANK = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Active-high pattern, a lit segment is 1; dp is never lit.
  function automatic logic [7:0] f_decode(input logic [3:0] code, input logic hex_en);
    logic [7:0] pat;
    case (code)
      4'h0:    pat = 8'h3F;
      4'h1:    pat = 8'h06;
      4'h2:    pat = 8'h5B;
      4'h3:    pat = 8'h4F;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'h6D;
      4'h6:    pat = 8'h7D;
      4'h7:    pat = 8'h07;
      4'h8:    pat = 8'h7F;
      4'h9:    pat = 8'h6F;
      4'hA:    pat = hex_en ? 8'h77 : 8'h00;
      4'hB:    pat = hex_en ? 8'h7C : 8'h00;
      4'hC:    pat = hex_en ? 8'h39 : 8'h00;
      4'hD:    pat = hex_en ? 8'h5E : 8'h00;
      4'hE:    pat = hex_en ? 8'h79 : 8'h00;
      4'hF:    pat = hex_en ? 8'h71 : 8'h00;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  logic [7:0] w_pattern;
  logic [7:0] r_out;

  // Polarity applies to the whole byte so dp and blanks follow the board convention.
  always_comb begin
    w_pattern = f_decode(in, HEX_EN);
    if (ACTIVE_LOW) begin
      w_pattern = ~w_pattern;
    end else begin
      w_pattern = w_pattern;
    end
  end

  // Output register; reset wins over the incoming code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= BLANK;
    end else begin
      r_out <= w_pattern;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_seg_decoder.sv
// Scoreboard bench for seg_decoder: three parameterisations share clk, rst and the code input.
module tb_seg_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_s;
  logic [7:0] out_def;
  logic [7:0] out_nohex;
  logic [7:0] out_al;

  always #5 clk = ~clk;

  seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_def (
    .clk(clk), .rst(rst), .in(in_s), .out(out_def)
  );
  seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_nohex (
    .clk(clk), .rst(rst), .in(in_s), .out(out_nohex)
  );
  seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_al (
    .clk(clk), .rst(rst), .in(in_s), .out(out_al)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] q_def[$];
  logic [7:0] q_nohex[$];
  logic [7:0] q_al[$];
  logic [7:0] e_def, e_nohex, e_al;

  // Reference: display table written out independently of the RTL.
  function automatic logic [7:0] model(input logic r, input logic [3:0] c, input bit hex, input bit al);
    logic [7:0] p;
    logic [7:0] digits [0:15];
    digits = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    if (r) p = 8'h00;
    else if (c > 4'd9 && !hex) p = 8'h00;
    else p = digits[c];
    return al ? ~p : p;
  endfunction

  task automatic drive(input logic r, input logic [3:0] c);
    @(negedge clk);
    rst  = r;
    in_s = c;
    q_def.push_back(model(r, c, 1'b1, 1'b0));
    q_nohex.push_back(model(r, c, 1'b0, 1'b0));
    q_al.push_back(model(r, c, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    e_def   = q_def.pop_front();
    e_nohex = q_nohex.pop_front();
    e_al    = q_al.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'h5);
      checks++;
      if (out_def !== e_def || out_def !== 8'h00) begin
        errors++;
        $display("FAIL reset_def cyc=%0d got=%h exp=%h", i, out_def, e_def);
      end
      checks++;
      if (out_al !== e_al) begin
        errors++;
        $display("FAIL reset_al cyc=%0d got=%h exp=%h", i, out_al, e_al);
      end
    end
    drive(1'b0, 4'h5);
    checks++;
    if (out_def !== e_def || out_def !== 8'h6D) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", out_def, e_def);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i));
      checks++;
      if (out_def !== e_def) begin
        errors++;
        $display("FAIL sweep_def code=%0d got=%h exp=%h", i, out_def, e_def);
      end
      checks++;
      if (out_nohex !== e_nohex) begin
        errors++;
        $display("FAIL sweep_nohex code=%0d got=%h exp=%h", i, out_nohex, e_nohex);
      end
      checks++;
      if (out_al !== e_al) begin
        errors++;
        $display("FAIL sweep_al code=%0d got=%h exp=%h", i, out_al, e_al);
      end
    end
  endtask

  task automatic test_latency();
    drive(1'b0, 4'h1);
    checks++;
    if (out_def !== e_def) begin
      errors++;
      $display("FAIL latency_first got=%h exp=%h", out_def, e_def);
    end
    #2;
    in_s = 4'h8;
    q_def.push_back(model(1'b0, 4'h8, 1'b1, 1'b0));
    #1;
    checks++;
    if (out_def !== 8'h06) begin
      errors++;
      $display("FAIL latency_hold got=%h exp=06", out_def);
    end
    @(posedge clk);
    #1;
    e_def = q_def.pop_front();
    checks++;
    if (out_def !== e_def || out_def !== 8'h7F) begin
      errors++;
      $display("FAIL latency_update got=%h exp=%h", out_def, e_def);
    end
  endtask

  task automatic test_hex_disabled();
    for (int i = 10; i < 16; i++) begin
      drive(1'b0, 4'(i));
      checks++;
      if (out_nohex !== e_nohex || out_nohex !== 8'h00) begin
        errors++;
        $display("FAIL nohex_blank code=%0d got=%h exp=%h", i, out_nohex, e_nohex);
      end
    end
    drive(1'b0, 4'h9);
    checks++;
    if (out_nohex !== e_nohex || out_nohex !== 8'h6F) begin
      errors++;
      $display("FAIL nohex_nine got=%h exp=%h", out_nohex, e_nohex);
    end
  endtask

  task automatic test_active_low();
    logic [3:0] codes [0:2];
    logic       rsts  [0:2];
    codes = '{4'h0, 4'h0, 4'h1};
    rsts  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(rsts[i], codes[i]);
      checks++;
      if (out_al !== e_al) begin
        errors++;
        $display("FAIL active_low step=%0d got=%h exp=%h", i, out_al, e_al);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic rsts [0:2];
    rsts = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(rsts[i], 4'h7);
      checks++;
      if (out_def !== e_def) begin
        errors++;
        $display("FAIL mid_reset_def step=%0d got=%h exp=%h", i, out_def, e_def);
      end
      checks++;
      if (out_al !== e_al) begin
        errors++;
        $display("FAIL mid_reset_al step=%0d got=%h exp=%h", i, out_al, e_al);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_s = 4'h0;
    test_reset();
    test_sweep();
    test_latency();
    test_hex_disabled();
    test_active_low();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
